// File: rtl/div_pkg.sv
// Shared definitions for the divider issue/collect stage and its helpers.
//   - div_state_e     : control FSM state encoding (IDLE, CLEAR, RUN, RESP)
//   - default_limit   : default watchdog limit for a given dividend width
//   - RSP_*_BIT       : bit positions of the response flags in the flag register
//   - pack_rsp_flags  : builds the flag vector from the individual flags
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } div_state_e;

    localparam int RSP_DIV0_BIT    = 0;
    localparam int RSP_TIMEOUT_BIT = 1;
    localparam int RSP_FLAG_W      = 2;

    // A bit-serial core needs about 2*N cycles; four cycles of slack on top.
    function automatic int default_limit(input int n);
        return 2 * n + 4;
    endfunction

    function automatic logic [RSP_FLAG_W-1:0] pack_rsp_flags(input logic div0,
                                                             input logic timeout);
        logic [RSP_FLAG_W-1:0] flags;
        flags                  = {RSP_FLAG_W{1'b0}};
        flags[RSP_DIV0_BIT]    = div0;
        flags[RSP_TIMEOUT_BIT] = timeout;
        return flags;
    endfunction

endpackage

// File: rtl/divider_issue_ctrl_if.sv
// Bundle of the request channel, the divider-core connection and the response
// channel of divider_issue_ctrl.
//   modport slave  : the issue controller itself
//   modport master : its environment (requester, divider core, response sink)
interface divider_issue_ctrl_if #(
    parameter int N = 5,
    parameter int M = 3
);
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] req_dividend;
    logic [M-1:0] req_divisor;
    logic         core_reset;
    logic         core_en;
    logic [N-1:0] core_dividend;
    logic [M-1:0] core_divisor;
    logic         core_ack;
    logic [N-1:0] core_merchant;
    logic [M-1:0] core_remainder;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_merchant;
    logic [M-1:0] rsp_remainder;
    logic         rsp_div0;
    logic         rsp_timeout;

    modport slave (
        input  req_valid, req_dividend, req_divisor,
        output req_ready,
        output core_reset, core_en, core_dividend, core_divisor,
        input  core_ack, core_merchant, core_remainder,
        output rsp_valid, rsp_merchant, rsp_remainder, rsp_div0, rsp_timeout,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_dividend, req_divisor,
        input  req_ready,
        input  core_reset, core_en, core_dividend, core_divisor,
        output core_ack, core_merchant, core_remainder,
        input  rsp_valid, rsp_merchant, rsp_remainder, rsp_div0, rsp_timeout,
        output rsp_ready
    );

endinterface

// File: rtl/div_watchdog.sv
// Saturating cycle counter with a limit compare, used to bound the wait for a
// divider core acknowledge.
//   CLK     : clock
//   RESET   : synchronous active-high reset (counter to 0)
//   clear   : synchronous counter clear
//   enable  : count this cycle
//   expired : the counter is at LIMIT, or reaches LIMIT on this enabled cycle
module div_watchdog #(
    parameter int LIMIT = 14
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W      = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C    = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1_C = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_r;

    // Counter: cleared on request, otherwise counts enabled cycles up to LIMIT
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != LIMIT_C)) begin
            count_r <= count_r + CNT_W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    // Expiry is flagged on the enabled cycle whose increment lands on LIMIT,
    // so the owner waits exactly LIMIT enabled cycles.
    assign expired = (count_r == LIMIT_C) | (enable & (count_r == LIMIT_M1_C));

endmodule

// File: rtl/divider_issue_ctrl.sv
// Issue/collect stage in front of a bit-serial divider core. Accepts a request,
// holds the operands for the core, clears the core, runs it until ACK (or a
// watchdog timeout) and presents the result on a response channel. A zero
// divisor is answered directly without touching the core.
//   CLK   : clock, rising edge
//   RESET : synchronous active-high reset; aborts any operation
//   bus   : request (req_*), core connection (core_*), response (rsp_*)
module divider_issue_ctrl
    import div_pkg::*;
#(
    parameter int N     = 5,
    parameter int M     = 3,
    parameter int LIMIT = default_limit(N)
) (
    input logic                 CLK,
    input logic                 RESET,
    divider_issue_ctrl_if.slave bus
);

    div_state_e            state_r;
    logic                  req_ready_r;
    logic                  core_reset_r;
    logic                  core_en_r;
    logic [N-1:0]          core_dividend_r;
    logic [M-1:0]          core_divisor_r;
    logic                  rsp_valid_r;
    logic [N-1:0]          rsp_merchant_r;
    logic [M-1:0]          rsp_remainder_r;
    logic [RSP_FLAG_W-1:0] rsp_flags_r;

    logic                  req_fire_s;
    logic                  rsp_fire_s;
    logic                  divisor_zero_s;
    logic [M-1:0]          div0_remainder_s;
    logic                  wd_clear_s;
    logic                  wd_enable_s;
    logic                  wd_expired_s;

    // Remainder reported for a zero divisor: low dividend bits, zero-extended
    generate
        if (N >= M) begin : g_rem_trunc
            assign div0_remainder_s = bus.req_dividend[M-1:0];
        end else begin : g_rem_ext
            assign div0_remainder_s = {{(M-N){1'b0}}, bus.req_dividend};
        end
    endgenerate

    // Handshake qualifiers and watchdog control
    always_comb begin
        req_fire_s     = bus.req_valid & req_ready_r;
        rsp_fire_s     = bus.rsp_ready & rsp_valid_r;
        divisor_zero_s = (bus.req_divisor == {M{1'b0}});
        wd_enable_s    = (state_r == RUN);
        wd_clear_s     = (state_r == RESP) & rsp_fire_s;
    end

    div_watchdog #(
        .LIMIT (LIMIT)
    ) u_watchdog (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (wd_clear_s),
        .enable  (wd_enable_s),
        .expired (wd_expired_s)
    );

    // Control FSM; every output is updated together with the state it belongs to
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r         <= IDLE;
            req_ready_r     <= 1'b0;
            core_reset_r    <= 1'b1;
            core_en_r       <= 1'b0;
            core_dividend_r <= {N{1'b0}};
            core_divisor_r  <= {M{1'b0}};
            rsp_valid_r     <= 1'b0;
            rsp_merchant_r  <= {N{1'b0}};
            rsp_remainder_r <= {M{1'b0}};
            rsp_flags_r     <= {RSP_FLAG_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    core_reset_r <= 1'b0;
                    core_en_r    <= 1'b0;
                    if (req_fire_s) begin
                        core_dividend_r <= bus.req_dividend;
                        core_divisor_r  <= bus.req_divisor;
                        req_ready_r     <= 1'b0;
                        if (divisor_zero_s) begin
                            rsp_merchant_r  <= {N{1'b1}};
                            rsp_remainder_r <= div0_remainder_s;
                            rsp_flags_r     <= pack_rsp_flags(1'b1, 1'b0);
                            rsp_valid_r     <= 1'b1;
                            state_r         <= RESP;
                        end else begin
                            core_reset_r <= 1'b1;
                            state_r      <= CLEAR;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                CLEAR: begin
                    // One-cycle core clear; any ACK seen here is stale
                    core_reset_r <= 1'b0;
                    core_en_r    <= 1'b1;
                    state_r      <= RUN;
                end
                RUN: begin
                    // ACK wins over a watchdog expiry in the same cycle
                    if (bus.core_ack) begin
                        rsp_merchant_r  <= bus.core_merchant;
                        rsp_remainder_r <= bus.core_remainder;
                        rsp_flags_r     <= pack_rsp_flags(1'b0, 1'b0);
                        rsp_valid_r     <= 1'b1;
                        core_en_r       <= 1'b0;
                        state_r         <= RESP;
                    end else if (wd_expired_s) begin
                        rsp_merchant_r  <= {N{1'b0}};
                        rsp_remainder_r <= {M{1'b0}};
                        rsp_flags_r     <= pack_rsp_flags(1'b0, 1'b1);
                        rsp_valid_r     <= 1'b1;
                        core_en_r       <= 1'b0;
                        state_r         <= RESP;
                    end else begin
                        core_en_r <= 1'b1;
                    end
                end
                RESP: begin
                    core_en_r <= 1'b0;
                    if (rsp_fire_s) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    req_ready_r  <= 1'b0;
                    core_reset_r <= 1'b1;
                    core_en_r    <= 1'b0;
                    rsp_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready      = req_ready_r;
    assign bus.core_reset     = core_reset_r;
    assign bus.core_en        = core_en_r;
    assign bus.core_dividend  = core_dividend_r;
    assign bus.core_divisor   = core_divisor_r;
    assign bus.rsp_valid      = rsp_valid_r;
    assign bus.rsp_merchant   = rsp_merchant_r;
    assign bus.rsp_remainder  = rsp_remainder_r;
    assign bus.rsp_div0       = rsp_flags_r[RSP_DIV0_BIT];
    assign bus.rsp_timeout    = rsp_flags_r[RSP_TIMEOUT_BIT];

endmodule

// File: tb/tb_divider_issue_ctrl.sv
// Self-checking bench for divider_issue_ctrl with a behavioural divider-core stub
// whose ACK delay (in core_en cycles) is programmable.
module tb_divider_issue_ctrl;

    localparam int N     = 5;
    localparam int M     = 3;
    localparam int LIMIT = 2 * N + 4;

    logic clk;
    logic rst;

    int n_vec;
    int n_err;

    int  stub_delay;
    bit  stub_never;
    int  stub_cnt;

    divider_issue_ctrl_if #(.N(N), .M(M)) bus ();

    divider_issue_ctrl #(
        .N     (N),
        .M     (M),
        .LIMIT (LIMIT)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stub: counts enabled cycles since its last reset; ACK once the
    // programmed number of enabled cycles has elapsed (including the current one).
    always @(posedge clk) begin
        if (bus.core_reset) stub_cnt <= 0;
        else if (bus.core_en) stub_cnt <= stub_cnt + 1;
    end
    assign bus.core_ack = bus.core_en && !stub_never && ((stub_cnt + 1) >= stub_delay);
    assign bus.core_merchant = (bus.core_divisor != 0) ?
                               N'(bus.core_dividend / bus.core_divisor) : {N{1'b1}};
    assign bus.core_remainder = (bus.core_divisor != 0) ?
                                M'(bus.core_dividend % bus.core_divisor) : {M{1'b1}};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sample once per cycle until rsp_valid; lat=1 is the cycle after the handshake edge
    task automatic wait_rsp(output int lat, output int crst, output int en_cyc);
        lat    = 1;
        crst   = int'(bus.core_reset);
        en_cyc = int'(bus.core_en);
        while (bus.rsp_valid !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            crst   += int'(bus.core_reset);
            en_cyc += int'(bus.core_en);
        end
    endtask

    task automatic rsp_handshake();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("rsp_valid_drop", bus.rsp_valid, 0);
        check("req_ready_back", bus.req_ready, 1);
    endtask

    // One full transaction checked against the arithmetic model of the stage
    task automatic run_txn(input int a, input int b, input int d, input bit never, input int stall);
        int exp_q, exp_r, exp_d0, exp_to, exp_lat, exp_k, exp_crst;
        int lat, crst, en_cyc;
        if (b == 0) begin
            exp_q = (1 << N) - 1; exp_r = a % (1 << M); exp_d0 = 1; exp_to = 0;
            exp_lat = 1; exp_k = 0; exp_crst = 0;
        end else if (!never && d <= LIMIT) begin
            exp_q = a / b; exp_r = a % b; exp_d0 = 0; exp_to = 0;
            exp_lat = 2 + d; exp_k = d; exp_crst = 1;
        end else begin
            exp_q = 0; exp_r = 0; exp_d0 = 0; exp_to = 1;
            exp_lat = 2 + LIMIT; exp_k = LIMIT; exp_crst = 1;
        end
        stub_delay = d;
        stub_never = never;
        check("req_ready_idle", bus.req_ready, 1);
        bus.req_valid    = 1'b1;
        bus.req_dividend = N'(a);
        bus.req_divisor  = M'(b);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_rsp(lat, crst, en_cyc);
        check("latency", lat, exp_lat);
        check("core_reset_cycles", crst, exp_crst);
        check("core_en_cycles", en_cyc, exp_k);
        check("core_dividend", bus.core_dividend, a);
        check("core_divisor", bus.core_divisor, b);
        for (int i = 0; i <= stall; i++) begin
            check("rsp_merchant", bus.rsp_merchant, exp_q);
            check("rsp_remainder", bus.rsp_remainder, exp_r);
            check("rsp_div0", bus.rsp_div0, exp_d0);
            check("rsp_timeout", bus.rsp_timeout, exp_to);
            check("req_ready_resp", bus.req_ready, 0);
            if (i < stall) begin
                @(posedge clk); #1;
                check("rsp_valid_hold", bus.rsp_valid, 1);
            end
        end
        rsp_handshake();
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int lat, crst, en_cyc, seen;
        n_vec = 0; n_err = 0;
        stub_delay = 1; stub_never = 1'b0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_dividend = '0; bus.req_divisor = '0; bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_core_reset", bus.core_reset, 1);
        check("rst_core_en", bus.core_en, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_merchant", bus.rsp_merchant, 0);
        check("rst_rsp_flags", {bus.rsp_div0, bus.rsp_timeout}, 0);
        check("rst_core_dividend", bus.core_dividend, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_req_ready", bus.req_ready, 1);
        check("post_rst_core_reset", bus.core_reset, 0);

        // Plain divide and divide-by-zero
        run_txn(23, 5, 3, 1'b0, 0);
        run_txn(7, 0, 3, 1'b0, 0);

        // Response stall with a second request waiting behind it
        stub_delay = 4; stub_never = 1'b0;
        bus.req_valid = 1'b1; bus.req_dividend = 5'd31; bus.req_divisor = 3'd7;
        @(posedge clk); #1;
        bus.req_dividend = 5'd0; bus.req_divisor = 3'd1;
        wait_rsp(lat, crst, en_cyc);
        check("t3_latency", lat, 6);
        for (int i = 0; i < 5; i++) begin
            check("t3_merchant", bus.rsp_merchant, 4);
            check("t3_remainder", bus.rsp_remainder, 3);
            check("t3_rsp_valid", bus.rsp_valid, 1);
            check("t3_req_ready", bus.req_ready, 0);
            @(posedge clk); #1;
        end
        check("t3_operand_hold", bus.core_dividend, 31);
        rsp_handshake();
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("t3_second_accept", bus.req_ready, 0);
        check("t3_second_clear", bus.core_reset, 1);
        wait_rsp(lat, crst, en_cyc);
        check("t3_second_latency", lat, 6);
        check("t3_second_merchant", bus.rsp_merchant, 0);
        check("t3_second_remainder", bus.rsp_remainder, 0);
        rsp_handshake();

        // Core never acknowledges
        run_txn(19, 3, 0, 1'b1, 1);

        // Reset in the middle of RUN
        stub_delay = 10; stub_never = 1'b0;
        bus.req_valid = 1'b1; bus.req_dividend = 5'd23; bus.req_divisor = 3'd5;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t5_in_run", bus.core_en, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_core_reset", bus.core_reset, 1);
        check("t5_core_en", bus.core_en, 0);
        check("t5_req_ready_low", bus.req_ready, 0);
        seen = int'(bus.rsp_valid);
        @(posedge clk); #1;
        check("t5_req_ready_high", bus.req_ready, 1);
        for (int i = 0; i < 15; i++) begin
            seen += int'(bus.rsp_valid);
            @(posedge clk); #1;
        end
        check("t5_no_response", seen, 0);
        run_txn(9, 2, 2, 1'b0, 0);

        // ACK on the very cycle the watchdog would expire, then one cycle too late
        run_txn(21, 4, LIMIT, 1'b0, 0);
        run_txn(21, 4, LIMIT + 1, 1'b0, 0);
        run_txn(30, 1, 1, 1'b0, 2);

        // Randomised traffic
        for (int t = 0; t < 40; t++) begin
            int a, b, d, s;
            a = int'($urandom_range(0, 31));
            b = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 7));
            d = int'($urandom_range(1, LIMIT + 3));
            s = int'($urandom_range(0, 3));
            run_txn(a, b, d, 1'b0, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
